lsu_wb_arbiter: RTL
===================

# lsu_wb_arbiter

Shares the single LSU writeback router between the two memory response sources: global memory (GM) and local data share (LDS). Each source has a one-entry holding buffer with a valid/ready handshake. A round-robin grant picks one buffered response per cycle and drives it, registered, onto the router's response inputs. A back-pressure input from the register-file side freezes the grant without losing data.

## Interface
Parameters:
- DATA_WIDTH, 8192: response data width (64 lanes x 128 bits).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_gm_valid  in  1  GM response present.
- out_gm_ready  out  1  GM buffer can accept this cycle.
- in_gm_rd_data  in  DATA_WIDTH  GM response data.
- in_gm_wftag  in  7  [6:1] wfid, [0] write-enable qualifier.
- in_gm_exec  in  64  lane exec mask.
- in_gm_addr  in  12  lddst/stsrc address; [11:10] = 10 VGPR, 11 SGPR, 0? none.
- in_gm_reg_wr_en  in  4  dword write enables.
- in_gm_pc  in  32  instruction PC.
- in_lds_*  in  same set and widths as in_gm_*; out_lds_ready  out  1.
- in_wb_stall  in  1  register file cannot take a writeback; no grant this cycle.
- out_ack  out  1  one-cycle strobe; the out_* fields below are valid.
- out_rd_data  out  DATA_WIDTH; out_wftag_resp  out  7; out_exec_value  out  64; out_lddst_stsrc_addr  out  12; out_reg_wr_en  out  4; out_instr_pc  out  32.
- out_gm_or_lds  out  1  source of the current response: 0 = GM, 1 = LDS.
- out_idle  out  1  both buffers empty and out_ack low.

## Operation
- Per-source buffer: one storage register plus a valid bit (buf_v).
- Ready rule: out_X_ready = !buf_v_X | grant_X. The grant is combinational in the same cycle.
- Capture rule: when in_X_valid & out_X_ready, the buffer loads the input and buf_v_X is set on the next edge.
- Clear rule: when a buffer is granted and there is no capture, buf_v_X clears.
- Grant rule: no grant if in_wb_stall. Otherwise:
  - only one buf_v set: grant that source;
  - both set: grant the source that was not granted last (last_gnt register).
- last_gnt updates only on a grant. Reset value is LDS, so GM wins the first tie.
- On grant:
  - all out_* fields load from the granted buffer on the next edge;
  - out_gm_or_lds loads the granted source id;
  - out_ack = 1 for exactly that cycle.
- Without a grant, out_ack = 0 and the data fields hold their last values (don't-care to the router).
- The payload is not inspected or modified. VGPR/SGPR routing and wftag[0] qualification remain the router's job.
- out_idle = !buf_v_gm & !buf_v_lds & !out_ack.

## Timing
- Latency: input accepted at edge N → buffer valid after N → grant in cycle N+1 → out_ack high in cycle N+2 (2 cycles, input valid to ack).
- Throughput: one ack per cycle total. A single unopposed source sustains 1/cycle because its ready is high in the same cycle as its grant.
- Two continuously valid sources alternate GM, LDS, GM, … with no bubbles.
- in_wb_stall high:
  - no grant and out_ack low on the next cycle;
  - full buffers deassert ready and hold their contents;
  - empty buffers still accept one entry.
- Simultaneous grant and capture on the same source: buffer reloads and buf_v stays 1.
- Reset, including mid-transfer:
  - buf_v_* = 0, last_gnt = LDS;
  - out_ack = 0, all out_* data fields = 0, out_gm_or_lds = 0;
  - out_idle = 1; out_*_ready = 1 after reset deasserts.
  - Buffered responses are discarded.

## Structure
- Shared package:
  - source id constants SRC_GM = 0, SRC_LDS = 1;
  - address-class constants (10 VGPR, 11 SGPR);
  - a response-bundle typedef (data, wftag, exec, addr, reg_wr_en, pc), reused by the router's input side.
- One sub-module: lsu_wb_resp_buf, the one-entry holding register with valid/ready. It is instantiated twice; the arbiter and output register are in the top level.

## Test plan
- Reset mid-traffic: assert rst with both buffers full → out_ack = 0, out_idle = 1, both ready = 1; no ack after release.
- GM only: valid at cycle 0 with pc = 0x100, addr = 0xA05 → out_ack in cycle 2, out_pc = 0x100, out_addr = 0xA05, out_gm_or_lds = 0.
- Tie: both valid every cycle starting in cycle 0 → acks from cycle 2 in order GM, LDS, GM, LDS; never two consecutive from the same source.
- Stall: both buffers full, in_wb_stall high for 3 cycles → no ack, both ready = 0, contents unchanged. After release, acks resume with the source not granted last, and no entry is lost or duplicated.
- Back-to-back single source: LDS valid for 8 consecutive cycles with pc = 0..7 → 8 consecutive acks in cycles 2..9 with out_gm_or_lds = 1 and pc in order.
- Simultaneous grant and capture: LDS buffer full and granted while a new LDS input arrives in the same cycle → ready = 1, new entry acked one cycle after the previous one.

Source files
------------

// File: rtl/lsu_wb_arbiter_pkg.sv
// Shared definitions for the LSU writeback path.
// Holds the source ids, address classes and the response bundle layout.
package lsu_wb_arbiter_pkg;

    localparam logic SRC_GM  = 1'b0;
    localparam logic SRC_LDS = 1'b1;

    // Upper two bits of lddst/stsrc select the register file; 0? means none.
    localparam logic [1:0] ADDR_CLASS_VGPR = 2'b10;
    localparam logic [1:0] ADDR_CLASS_SGPR = 2'b11;

    localparam int RESP_DATA_W = 8192;
    localparam int WFTAG_W     = 7;
    localparam int EXEC_W      = 64;
    localparam int ADDR_W      = 12;
    localparam int WR_EN_W     = 4;
    localparam int PC_W        = 32;

    typedef struct packed {
        logic [WFTAG_W-1:0] wftag;
        logic [EXEC_W-1:0]  exec;
        logic [ADDR_W-1:0]  addr;
        logic [WR_EN_W-1:0] reg_wr_en;
        logic [PC_W-1:0]    pc;
    } resp_meta_t;

    localparam int META_W = $bits(resp_meta_t);

    typedef struct packed {
        logic [RESP_DATA_W-1:0] data;
        resp_meta_t             meta;
    } resp_t;

endpackage

// File: rtl/lsu_wb_resp_buf.sv
// One-entry response holding register with a valid/ready input handshake.
// The entry leaves when the arbiter grants it; it can be refilled in the same cycle.
module lsu_wb_resp_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         out_ready,
    input  logic [W-1:0] in_payload,
    input  logic         grant,
    output logic         buf_v,
    output logic [W-1:0] buf_payload
);

    // Handshake: a transfer happens on a rising edge where in_valid and
    // out_ready are both high; a source holds its payload until then.
    logic capture;

    assign out_ready = !buf_v | grant;
    assign capture   = in_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_v       <= 1'b0;
            buf_payload <= '0;
        end else if (capture) begin
            buf_v       <= 1'b1;
            buf_payload <= in_payload;
        end else if (grant) begin
            buf_v       <= 1'b0;
        end
    end

endmodule

// File: rtl/lsu_wb_arbiter.sv
// Round-robin arbiter sharing the LSU writeback router between GM and LDS responses.
// The granted buffer is registered onto the router inputs; in_wb_stall blocks grants.
module lsu_wb_arbiter
    import lsu_wb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8192
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_gm_valid,
    output logic                  out_gm_ready,
    input  logic [DATA_WIDTH-1:0] in_gm_rd_data,
    input  logic [6:0]            in_gm_wftag,
    input  logic [63:0]           in_gm_exec,
    input  logic [11:0]           in_gm_addr,
    input  logic [3:0]            in_gm_reg_wr_en,
    input  logic [31:0]           in_gm_pc,
    input  logic                  in_lds_valid,
    output logic                  out_lds_ready,
    input  logic [DATA_WIDTH-1:0] in_lds_rd_data,
    input  logic [6:0]            in_lds_wftag,
    input  logic [63:0]           in_lds_exec,
    input  logic [11:0]           in_lds_addr,
    input  logic [3:0]            in_lds_reg_wr_en,
    input  logic [31:0]           in_lds_pc,
    input  logic                  in_wb_stall,
    output logic                  out_ack,
    output logic [DATA_WIDTH-1:0] out_rd_data,
    output logic [6:0]            out_wftag_resp,
    output logic [63:0]           out_exec_value,
    output logic [11:0]           out_lddst_stsrc_addr,
    output logic [3:0]            out_reg_wr_en,
    output logic [31:0]           out_instr_pc,
    output logic                  out_gm_or_lds,
    output logic                  out_idle
);

    localparam int W = DATA_WIDTH + META_W;

    resp_meta_t      gm_meta, lds_meta, sel_meta;
    logic [W-1:0]    gm_payload, lds_payload;
    logic [W-1:0]    buf_gm_payload, buf_lds_payload, sel_payload;
    logic            buf_v_gm, buf_v_lds;
    logic            gnt_gm, gnt_lds, gnt_any;
    logic            last_gnt;

    always_comb begin
        gm_meta           = '0;
        gm_meta.wftag     = in_gm_wftag;
        gm_meta.exec      = in_gm_exec;
        gm_meta.addr      = in_gm_addr;
        gm_meta.reg_wr_en = in_gm_reg_wr_en;
        gm_meta.pc        = in_gm_pc;
        lds_meta           = '0;
        lds_meta.wftag     = in_lds_wftag;
        lds_meta.exec      = in_lds_exec;
        lds_meta.addr      = in_lds_addr;
        lds_meta.reg_wr_en = in_lds_reg_wr_en;
        lds_meta.pc        = in_lds_pc;
    end

    assign gm_payload  = {in_gm_rd_data, gm_meta};
    assign lds_payload = {in_lds_rd_data, lds_meta};

    lsu_wb_resp_buf #(.W(W)) u_gm_buf (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_gm_valid),
        .out_ready   (out_gm_ready),
        .in_payload  (gm_payload),
        .grant       (gnt_gm),
        .buf_v       (buf_v_gm),
        .buf_payload (buf_gm_payload)
    );

    lsu_wb_resp_buf #(.W(W)) u_lds_buf (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_lds_valid),
        .out_ready   (out_lds_ready),
        .in_payload  (lds_payload),
        .grant       (gnt_lds),
        .buf_v       (buf_v_lds),
        .buf_payload (buf_lds_payload)
    );

    // On a tie the source that did not win last time gets the router.
    always_comb begin
        gnt_gm  = 1'b0;
        gnt_lds = 1'b0;
        if (!in_wb_stall) begin
            if (buf_v_gm && buf_v_lds) begin
                gnt_gm  = (last_gnt == SRC_LDS);
                gnt_lds = (last_gnt == SRC_GM);
            end else begin
                gnt_gm  = buf_v_gm;
                gnt_lds = buf_v_lds;
            end
        end
    end

    assign gnt_any     = gnt_gm | gnt_lds;
    assign sel_payload = gnt_lds ? buf_lds_payload : buf_gm_payload;
    assign sel_meta    = resp_meta_t'(sel_payload[META_W-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= SRC_LDS;
        end else if (gnt_gm) begin
            last_gnt <= SRC_GM;
        end else if (gnt_lds) begin
            last_gnt <= SRC_LDS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_ack              <= 1'b0;
            out_rd_data          <= '0;
            out_wftag_resp       <= '0;
            out_exec_value       <= '0;
            out_lddst_stsrc_addr <= '0;
            out_reg_wr_en        <= '0;
            out_instr_pc         <= '0;
            out_gm_or_lds        <= SRC_GM;
        end else begin
            out_ack <= gnt_any;
            if (gnt_any) begin
                out_rd_data          <= sel_payload[W-1:META_W];
                out_wftag_resp       <= sel_meta.wftag;
                out_exec_value       <= sel_meta.exec;
                out_lddst_stsrc_addr <= sel_meta.addr;
                out_reg_wr_en        <= sel_meta.reg_wr_en;
                out_instr_pc         <= sel_meta.pc;
                out_gm_or_lds        <= gnt_lds ? SRC_LDS : SRC_GM;
            end
        end
    end

    assign out_idle = !buf_v_gm & !buf_v_lds & !out_ack;

endmodule
